adt7420_poller: RTL

//  Autonomous temperature-sensor sequencer sitting directly upstream of the i2c_wrapper transaction block.

---
 rtl/adt7420_poller.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adt7420_poller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adt7420_poller                                             |
// | Description : Configures an ADT7420 once after reset, then periodically  |
// |               reads the temperature MSB/LSB through the i2c_wrapper and  |
// |               publishes validated samples with error/timeout accounting. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module adt7420_poller #(
  parameter logic [6:0] SENSOR_ADDR    = 7'h4B,
  parameter logic [7:0] CONFIG_VAL     = 8'h00,
  parameter int         POLL_CYCLES    = 25_000_000,
  parameter int         TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  output logic        o_i2c_start,
  output logic        o_i2c_rd_wr,
  output logic [7:0]  o_i2c_reg_addr,
  output logic [6:0]  o_i2c_bus_addr,
  output logic [7:0]  o_i2c_wdata,
  input  logic [7:0]  i_i2c_rdata,
  input  logic        i_i2c_busy,
  input  logic        i_i2c_done,
  input  logic        i_i2c_error,
  output logic [15:0] o_temp_raw,
  output logic [8:0]  o_temp_degc,
  output logic        o_temp_valid,
  output logic        o_cfg_done,
  output logic        o_err_flag,
  output logic [7:0]  o_err_count
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [POLL_W-1:0] c_poll_last = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TMO_W-1:0]  c_tmo_last  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        c_reg_msb   = 8'h00;
  localparam logic [7:0]        c_reg_lsb   = 8'h01;
  localparam logic [7:0]        c_reg_cfg   = 8'h03;

  typedef enum logic [2:0] {
    CFG_START = 3'd0,
    CFG_WAIT  = 3'd1,
    POLL_WAIT = 3'd2,
    MSB_START = 3'd3,
    MSB_WAIT  = 3'd4,
    LSB_START = 3'd5,
    LSB_WAIT  = 3'd6,
    PUBLISH   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [POLL_W-1:0]   r_poll_cnt;
  logic [TMO_W-1:0]    r_wait_cnt;
  logic [1:0]          r_done_cnt;
  logic                r_done_q;
  logic [7:0]          r_msb_hold;
  logic                r_start;
  logic                r_rd_wr;
  logic [7:0]          r_reg_addr;
  logic [7:0]          r_wdata;
  logic [15:0]         r_temp_raw;
  logic                r_temp_valid;
  logic                r_cfg_done;
  logic                r_err_flag;
  logic [7:0]          r_err_count;

  logic w_done_rise;
  logic w_in_wait;
  logic w_timeout;
  logic w_fire;
  logic w_fail;
  logic w_cfg_ok;
  logic w_cap_msb;
  logic w_cap_lsb;
  logic w_poll_expire;

  // Only a fresh done pulse counts, so a stretched done is never seen twice.
  assign w_done_rise = i_i2c_done & ~r_done_q;
  assign w_in_wait   = (r_state == CFG_WAIT) || (r_state == MSB_WAIT) || (r_state == LSB_WAIT);
  assign w_timeout   = w_in_wait && (r_wait_cnt == c_tmo_last);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CFG_START;
    else     r_state <= w_next;
  end

  // Next-state decode and single-cycle control strobes; error beats done.
  always_comb begin
    w_next        = r_state;
    w_fire        = 1'b0;
    w_fail        = 1'b0;
    w_cfg_ok      = 1'b0;
    w_cap_msb     = 1'b0;
    w_cap_lsb     = 1'b0;
    w_poll_expire = 1'b0;
    case (r_state)
      CFG_START: begin
        if (!i_i2c_busy) begin
          w_fire = 1'b1;
          w_next = CFG_WAIT;
        end
      end
      CFG_WAIT: begin
        if (i_i2c_error || w_timeout) begin
          w_fail = 1'b1;
          w_next = POLL_WAIT;
        end else if (w_done_rise) begin
          w_cfg_ok = 1'b1;
          w_next   = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (i_enable && (r_poll_cnt == c_poll_last)) begin
          w_poll_expire = 1'b1;
          w_next        = r_cfg_done ? MSB_START : CFG_START;
        end
      end
      MSB_START: begin
        if (!i_i2c_busy) begin
          w_fire = 1'b1;
          w_next = MSB_WAIT;
        end
      end
      MSB_WAIT: begin
        if (i_i2c_error || w_timeout) begin
          w_fail = 1'b1;
          w_next = POLL_WAIT;
        end else if (w_done_rise && (r_done_cnt == 2'd1)) begin
          w_cap_msb = 1'b1;
          w_next    = LSB_START;
        end
      end
      LSB_START: begin
        if (!i_i2c_busy) begin
          w_fire = 1'b1;
          w_next = LSB_WAIT;
        end
      end
      LSB_WAIT: begin
        if (i_i2c_error || w_timeout) begin
          w_fail = 1'b1;
          w_next = POLL_WAIT;
        end else if (w_done_rise && (r_done_cnt == 2'd1)) begin
          w_cap_lsb = 1'b1;
          w_next    = PUBLISH;
        end
      end
      PUBLISH: begin
        w_next = POLL_WAIT;
      end
      default: begin
        w_next = CFG_START;
      end
    endcase
  end

  // Poll, wait and done counters; the wait-side counters restart whenever a transaction is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll_cnt <= '0;
      r_wait_cnt <= '0;
      r_done_cnt <= 2'd0;
      r_done_q   <= 1'b0;
    end else begin
      r_done_q <= i_i2c_done;
      if ((r_state == POLL_WAIT) && i_enable && !w_poll_expire)
        r_poll_cnt <= r_poll_cnt + POLL_W'(1);
      else
        r_poll_cnt <= '0;
      if (w_fire) begin
        r_wait_cnt <= '0;
        r_done_cnt <= 2'd0;
      end else if (w_in_wait) begin
        r_wait_cnt <= r_wait_cnt + TMO_W'(1);
        if (w_done_rise && (r_done_cnt != 2'd3))
          r_done_cnt <= r_done_cnt + 2'd1;
      end
    end
  end

  // Wrapper request: start is a one-cycle pulse, the rest is held until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start    <= 1'b0;
      r_rd_wr    <= 1'b0;
      r_reg_addr <= 8'h00;
      r_wdata    <= 8'h00;
    end else begin
      r_start <= w_fire;
      if (w_fire) begin
        case (r_state)
          CFG_START: begin
            r_rd_wr    <= 1'b0;
            r_reg_addr <= c_reg_cfg;
            r_wdata    <= CONFIG_VAL;
          end
          MSB_START: begin
            r_rd_wr    <= 1'b1;
            r_reg_addr <= c_reg_msb;
            r_wdata    <= 8'h00;
          end
          default: begin
            r_rd_wr    <= 1'b1;
            r_reg_addr <= c_reg_lsb;
            r_wdata    <= 8'h00;
          end
        endcase
      end
    end
  end

  // Sample capture, publish pulse and error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msb_hold   <= 8'h00;
      r_temp_raw   <= 16'h0000;
      r_temp_valid <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_err_flag   <= 1'b0;
      r_err_count  <= 8'h00;
    end else begin
      r_temp_valid <= w_cap_lsb;
      if (w_cfg_ok)
        r_cfg_done <= 1'b1;
      if (w_cap_msb)
        r_msb_hold <= i_i2c_rdata;
      if (w_cap_lsb) begin
        r_temp_raw <= {r_msb_hold, i_i2c_rdata};
        r_err_flag <= 1'b0;
      end
      if (w_fail) begin
        r_err_flag <= 1'b1;
        if (r_err_count != 8'hFF)
          r_err_count <= r_err_count + 8'h01;
      end
    end
  end

  assign o_i2c_start    = r_start;
  assign o_i2c_rd_wr    = r_rd_wr;
  assign o_i2c_reg_addr = r_reg_addr;
  assign o_i2c_bus_addr = SENSOR_ADDR;
  assign o_i2c_wdata    = r_wdata;
  assign o_temp_raw     = r_temp_raw;
  assign o_temp_degc    = r_temp_raw[15:7];
  assign o_temp_valid   = r_temp_valid;
  assign o_cfg_done     = r_cfg_done;
  assign o_err_flag     = r_err_flag;
  assign o_err_count    = r_err_count;

endmodule
`default_nettype wire
